// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake and operand/product bus for the shift-add multiplier.
// The master launches a multiply; the multiplier is the slave.
interface shift_add_multiplier_if #(
    parameter int n = 8
);
    logic             start;
    logic [n-1:0]     a;
    logic [n-1:0]     b;
    logic [2*n-1:0]   product;
    logic             busy;
    logic             done;

    modport master (output start, a, b, input product, busy, done);
    modport slave  (input start, a, b, output product, busy, done);
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned n x n -> 2n multiplier: one n-bit ripple adder reused
// over n add/shift steps, sequenced by an IDLE/CALC/DONE FSM.
module FA_str (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_x, w_g, w_p;

    xor g_x0 (w_x, i_a, i_b);
    xor g_x1 (o_s, w_x, i_c);
    and g_a0 (w_g, i_a, i_b);
    and g_a1 (w_p, w_x, i_c);
    or  g_o0 (o_c, w_g, w_p);
endmodule

module Nbit_Adder #(
    parameter int n = 8
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  logic         i_cin,
    output logic [n-1:0] o_sum,
    output logic         o_cout
);
    logic [n:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < n; gi++) begin : g_fa
        FA_str u_fa (
            .i_a (i_a[gi]),
            .i_b (i_b[gi]),
            .i_c (w_c[gi]),
            .o_s (o_sum[gi]),
            .o_c (w_c[gi+1])
        );
    end

    assign o_cout = w_c[n];
endmodule

module shift_add_multiplier #(
    parameter int n = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    shift_add_multiplier_if.slave  s_if
);
    localparam int CW = $clog2(n) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [n-1:0]     r_m, w_m_nxt;
    logic [2*n-1:0]   r_p, w_p_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic [n-1:0]     w_sum;
    logic             w_cout;
    logic             w_busy, w_done;

    // Upper half of P plus multiplicand; carry-in tied low.
    Nbit_Adder #(.n(n)) u_add (
        .i_a    (r_p[2*n-1:n]),
        .i_b    (r_m),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_p     <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_m     <= w_m_nxt;
            r_p     <= w_p_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_p_nxt     = r_p;
        w_count_nxt = r_count;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (s_if.start) begin
                    w_m_nxt     = s_if.a;
                    w_p_nxt     = {{n{1'b0}}, s_if.b};
                    w_count_nxt = '0;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                // Carry-out lands in the MSB so no product bit is lost.
                if (r_p[0])
                    w_p_nxt = {w_cout, w_sum, r_p[n-1:1]};
                else
                    w_p_nxt = {1'b0, r_p[2*n-1:1]};
                w_count_nxt = r_count + 1'b1;
                if (r_count == CW'(n - 1))
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign s_if.product = r_p;
    assign s_if.busy    = w_busy;
    assign s_if.done    = w_done;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (n=8): expected products queued at
// launch, popped and checked against product/latency on every done pulse.
module tb_shift_add_multiplier;
    localparam int N = 8;

    typedef struct {
        logic [2*N-1:0] exp;
        int             st;
    } sb_t;

    logic clk;
    logic rst;
    int   cyc    = 0;
    int   n_run  = 0;
    int   n_fail = 0;
    bit   sweep  = 0;
    int   last_done = -1;
    sb_t  q[$];

    shift_add_multiplier_if #(.n(N)) mif ();

    shift_add_multiplier #(.n(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_if  (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Drive a one-cycle start at the next edge and queue the expected result.
    task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tb);
        sb_t e;
        @(negedge clk);
        mif.a     = ta;
        mif.b     = tb;
        mif.start = 1'b1;
        e.exp = (2*N)'(ta) * (2*N)'(tb);
        e.st  = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        mif.start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mif.done) begin
            if (q.size() == 0) begin
                chk("unexp_done", 32'(mif.done), 32'd0);
            end else begin
                sb_t e;
                e = q.pop_front();
                chk("product", 32'(mif.product), 32'(e.exp));
                chk("latency", 32'(cyc - e.st), 32'(N));
                if (sweep && last_done >= 0)
                    chk("spacing", 32'(cyc - last_done), 32'(N + 2));
                last_done = cyc;
            end
        end
    end

    initial begin
        sb_t e;
        rst = 1'b1;
        mif.start = 1'b1;
        mif.a = 8'd5;
        mif.b = 8'd5;

        // Reset held two cycles with start asserted.
        repeat (2) @(negedge clk);
        chk("rst_product", 32'(mif.product), 32'd0);
        chk("rst_busy",    32'(mif.busy),    32'd0);
        chk("rst_done",    32'(mif.done),    32'd0);
        rst = 1'b0;
        mif.start = 1'b0;
        @(negedge clk);
        chk("rst_no_start", 32'(mif.busy), 32'd0);

        // Basic multiply: busy from E0, partial = {0,b}, result held after done.
        launch(8'd13, 8'd11);
        chk("basic_busy", 32'(mif.busy), 32'd1);
        chk("basic_p0",   32'(mif.product), 32'd11);
        repeat (8) @(negedge clk);
        chk("basic_done_hi", 32'(mif.done), 32'd1);
        @(negedge clk);
        chk("basic_done_lo", 32'(mif.done), 32'd0);
        chk("basic_idle",    32'(mif.busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("basic_hold", 32'(mif.product), 32'd143);

        launch(8'd255, 8'd255);
        repeat (12) @(negedge clk);
        chk("max_hold", 32'(mif.product), 32'd65025);
        launch(8'd1, 8'd200);
        repeat (12) @(negedge clk);
        launch(8'd0, 8'd255);
        repeat (12) @(negedge clk);

        // Starts during CALC and DONE must be ignored.
        launch(8'd7, 8'd9);
        repeat (2) @(negedge clk);
        mif.a = 8'd3;
        mif.b = 8'd3;
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (5) @(negedge clk);
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        chk("busy_ignored_idle", 32'(mif.busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("busy_result", 32'(mif.product), 32'd63);
        launch(8'd3, 8'd3);
        repeat (12) @(negedge clk);

        // Reset sampled at E4 of CALC aborts with no done.
        launch(8'd200, 8'd150);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("abort_busy",    32'(mif.busy),    32'd0);
        chk("abort_product", 32'(mif.product), 32'd0);
        chk("abort_done",    32'(mif.done),    32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        launch(8'd200, 8'd150);
        repeat (12) @(negedge clk);
        chk("abort_redo", 32'(mif.product), 32'd30000);

        // Back-to-back sweep with start held high.
        sweep = 1'b1;
        last_done = -1;
        @(negedge clk);
        mif.a = 8'($urandom_range(0, 255));
        mif.b = 8'($urandom_range(0, 255));
        mif.start = 1'b1;
        e.exp = 16'(mif.a) * 16'(mif.b);
        e.st  = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        for (int i = 1; i < 500; i++) begin
            mif.a = 8'($urandom_range(0, 255));
            mif.b = 8'($urandom_range(0, 255));
            e.exp = 16'(mif.a) * 16'(mif.b);
            e.st  = cyc + N + 2;
            q.push_back(e);
            repeat (N + 2) @(negedge clk);
        end
        mif.start = 1'b0;
        repeat (12) @(negedge clk);
        sweep = 1'b0;

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
